// File: rtl/mt_thread_sched_if.sv
// Scheduler bundle: execute-side start/halt events and stalls in, fetch slot to mt_pc out.
interface mt_thread_sched_if #(
    parameter int NUM_THREADS  = 8,
    parameter int BITS_THREADS = $clog2(NUM_THREADS)
);
    logic                    run;
    logic                    start_valid;
    logic [BITS_THREADS-1:0] start_tid;
    logic                    halt_valid;
    logic [BITS_THREADS-1:0] halt_tid;
    logic [NUM_THREADS-1:0]  stall_mask;
    logic [BITS_THREADS-1:0] tid;
    logic                    tid_valid;
    logic [NUM_THREADS-1:0]  active_mask;
    logic                    idle;

    modport master (
        output run, start_valid, start_tid, halt_valid, halt_tid, stall_mask,
        input  tid, tid_valid, active_mask, idle
    );

    modport slave (
        input  run, start_valid, start_tid, halt_valid, halt_tid, stall_mask,
        output tid, tid_valid, active_mask, idle
    );
endinterface

// File: rtl/mt_thread_sched.sv
// Barrel thread scheduler feeding mt_pc: one registered tid per cycle, either fixed
// round-robin slots (STRICT=1) or skip-ahead to the next ready thread (STRICT=0).
module mt_thread_sched #(
    parameter int                     NUM_THREADS  = 8,
    parameter int                     BITS_THREADS = $clog2(NUM_THREADS),
    parameter bit                     STRICT       = 1'b1,
    parameter logic [NUM_THREADS-1:0] RESET_MASK   = NUM_THREADS'(1)
) (
    input logic              clk,
    input logic              rst,
    mt_thread_sched_if.slave bus
);
    logic [BITS_THREADS-1:0] ptr;
    logic [BITS_THREADS-1:0] tid_q;
    logic                    tid_valid_q;
    logic [NUM_THREADS-1:0]  active_mask;
    logic [NUM_THREADS-1:0]  mask_nxt;
    logic [NUM_THREADS-1:0]  ready;
    logic [BITS_THREADS-1:0] sel_idx;
    logic [BITS_THREADS-1:0] cand;
    logic                    sel_vld;
    logic                    advance;

    // Readiness uses the mask as it stands before this edge's start/halt events.
    assign ready = active_mask & ~bus.stall_mask;

    always_comb begin
        sel_idx = ptr;
        sel_vld = 1'b0;
        cand    = '0;
        if (STRICT) begin
            sel_idx = ptr + 1'b1;
            sel_vld = ready[sel_idx];
        end else begin
            // Walk farthest-to-nearest so the closest ready thread overwrites; i=N wraps to ptr.
            for (int i = NUM_THREADS; i >= 1; i--) begin
                cand = ptr + BITS_THREADS'(i);
                if (ready[cand]) begin
                    sel_idx = cand;
                    sel_vld = 1'b1;
                end
            end
        end
    end

    // Strict mode burns the slot even for a bubble; skip mode only moves on a hit.
    assign advance = bus.run & (STRICT | sel_vld);

    always_comb begin
        mask_nxt = active_mask;
        if (bus.start_valid) mask_nxt[bus.start_tid] = 1'b1;
        if (bus.halt_valid)  mask_nxt[bus.halt_tid]  = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr         <= '1;
            tid_q       <= '0;
            tid_valid_q <= 1'b0;
            active_mask <= RESET_MASK;
        end else begin
            active_mask <= mask_nxt;
            tid_valid_q <= bus.run & sel_vld;
            if (advance) begin
                ptr   <= sel_idx;
                tid_q <= sel_idx;
            end
        end
    end

    assign bus.tid         = tid_q;
    assign bus.tid_valid   = tid_valid_q;
    assign bus.active_mask = active_mask;
    assign bus.idle        = (active_mask == '0);
endmodule

// File: tb/tb_mt_thread_sched.sv
// Scoreboard bench: three scheduler configurations share one random/directed stimulus stream.
module tb_mt_thread_sched;
    localparam int N = 8;
    localparam int B = 3;

    typedef struct {
        logic [B-1:0] tid;
        logic         vld;
        logic [N-1:0] mask;
    } exp_t;

    localparam bit         STR [3] = '{1'b1, 1'b0, 1'b1};
    localparam logic [7:0] RM  [3] = '{8'hFF, 8'h05, 8'h01};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mt_thread_sched_if #(.NUM_THREADS(N)) ifa ();
    mt_thread_sched_if #(.NUM_THREADS(N)) ifb ();
    mt_thread_sched_if #(.NUM_THREADS(N)) ifc ();

    mt_thread_sched #(.NUM_THREADS(N), .STRICT(1'b1), .RESET_MASK(8'hFF))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    mt_thread_sched #(.NUM_THREADS(N), .STRICT(1'b0), .RESET_MASK(8'h05))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));
    mt_thread_sched dut_c (.clk(clk), .rst(rst), .bus(ifc));

    int   m_ptr  [3];
    int   m_tid  [3];
    bit   m_act  [3][N];
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   compared   = 0;
    int   mismatched = 0;
    bit   mon_en     = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        logic [7:0] r;
        for (int k = 0; k < 3; k++) begin
            r        = RM[k];
            m_ptr[k] = N - 1;
            m_tid[k] = 0;
            for (int i = 0; i < N; i++) m_act[k][i] = r[i];
        end
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    // Reference: next slot from the rules (rotation or nearest ready), then mask events.
    task automatic model_step(bit run, bit sv, int st, bit hv, int ht, logic [N-1:0] stall);
        bit           rdy [N];
        bit           vld;
        int           j;
        exp_t         e;
        logic [N-1:0] mk;
        for (int k = 0; k < 3; k++) begin
            vld = 1'b0;
            for (int i = 0; i < N; i++) rdy[i] = m_act[k][i] && !stall[i];
            if (run) begin
                if (STR[k]) begin
                    m_ptr[k] = (m_ptr[k] + 1) % N;
                    m_tid[k] = m_ptr[k];
                    vld      = rdy[m_ptr[k]];
                end else begin
                    for (int s = 1; s <= N; s++) begin
                        j = (m_ptr[k] + s) % N;
                        if (!vld && rdy[j]) begin
                            vld      = 1'b1;
                            m_ptr[k] = j;
                            m_tid[k] = j;
                        end
                    end
                end
            end
            if (sv) m_act[k][st] = 1'b1;
            if (hv) m_act[k][ht] = 1'b0;
            for (int i = 0; i < N; i++) mk[i] = m_act[k][i];
            e.tid  = B'(m_tid[k]);
            e.vld  = vld;
            e.mask = mk;
            case (k)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    task automatic cyc(bit run, bit sv, int st, bit hv, int ht, logic [N-1:0] stall);
        @(negedge clk);
        ifa.run = run; ifa.start_valid = sv; ifa.start_tid = B'(st);
        ifa.halt_valid = hv; ifa.halt_tid = B'(ht); ifa.stall_mask = stall;
        ifb.run = run; ifb.start_valid = sv; ifb.start_tid = B'(st);
        ifb.halt_valid = hv; ifb.halt_tid = B'(ht); ifb.stall_mask = stall;
        ifc.run = run; ifc.start_valid = sv; ifc.start_tid = B'(st);
        ifc.halt_valid = hv; ifc.halt_tid = B'(ht); ifc.stall_mask = stall;
        model_step(run, sv, st, hv, ht, stall);
        mon_en = 1'b1;
    endtask

    task automatic chk_reset(int k, logic [B-1:0] t, logic v, logic [N-1:0] m, logic idl);
        logic [7:0] r;
        r = RM[k];
        chk($sformatf("rst_tid[%0d]", k), 32'(t), 32'd0);
        chk($sformatf("rst_tid_valid[%0d]", k), 32'(v), 32'd0);
        chk($sformatf("rst_mask[%0d]", k), 32'(m), 32'(r));
        chk($sformatf("rst_idle[%0d]", k), 32'(idl), 32'(r == 8'h00));
    endtask

    // Asserted mid-cycle with no clock edge before the check; released before the next negedge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        rst    = 1'b0;
        #1;
        chk_reset(0, ifa.tid, ifa.tid_valid, ifa.active_mask, ifa.idle);
        chk_reset(1, ifb.tid, ifb.tid_valid, ifb.active_mask, ifb.idle);
        chk_reset(2, ifc.tid, ifc.tid_valid, ifc.active_mask, ifc.idle);
        model_reset();
        rst = 1'b1;
    endtask

    task automatic check_inst(int k, logic [B-1:0] t, logic v, logic [N-1:0] m, logic idl);
        exp_t e;
        int   sz;
        case (k)
            0:       sz = q0.size();
            1:       sz = q1.size();
            default: sz = q2.size();
        endcase
        if (sz == 0) begin
            compared++;
            mismatched++;
            $display("FAIL inst%0d: output with no expected entry at %0t", k, $time);
            return;
        end
        case (k)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        chk($sformatf("tid_valid[%0d]", k), 32'(v), 32'(e.vld));
        chk($sformatf("tid[%0d]", k), 32'(t), 32'(e.tid));
        chk($sformatf("active_mask[%0d]", k), 32'(m), 32'(e.mask));
        chk($sformatf("idle[%0d]", k), 32'(idl), 32'(e.mask == '0));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                check_inst(0, ifa.tid, ifa.tid_valid, ifa.active_mask, ifa.idle);
                check_inst(1, ifb.tid, ifb.tid_valid, ifb.active_mask, ifb.idle);
                check_inst(2, ifc.tid, ifc.tid_valid, ifc.active_mask, ifc.idle);
            end
        end
    end

    initial begin
        logic [N-1:0] stall;
        ifa.run = 0; ifa.start_valid = 0; ifa.start_tid = '0; ifa.halt_valid = 0; ifa.halt_tid = '0; ifa.stall_mask = '0;
        ifb.run = 0; ifb.start_valid = 0; ifb.start_tid = '0; ifb.halt_valid = 0; ifb.halt_tid = '0; ifb.stall_mask = '0;
        ifc.run = 0; ifc.start_valid = 0; ifc.start_tid = '0; ifc.halt_valid = 0; ifc.halt_tid = '0; ifc.stall_mask = '0;
        model_reset();
        do_reset();

        // full rotation 0..7,0
        repeat (9) cyc(1, 0, 0, 0, 0, '0);

        // skip mode with thread 0 stalled on the third selection: 0,2,2,0,2
        do_reset();
        cyc(1, 0, 0, 0, 0, '0);
        cyc(1, 0, 0, 0, 0, '0);
        cyc(1, 0, 0, 0, 0, 8'h01);
        cyc(1, 0, 0, 0, 0, '0);
        cyc(1, 0, 0, 0, 0, '0);

        // default instance becomes mask 05: valid only on slots 0 and 2
        cyc(1, 1, 2, 0, 0, '0);
        repeat (10) cyc(1, 0, 0, 0, 0, '0);

        // start+halt same tid: halt wins; then start alone sets it
        cyc(1, 1, 3, 1, 3, '0);
        cyc(1, 1, 3, 0, 0, '0);
        cyc(1, 1, 6, 1, 1, '0);
        cyc(1, 1, 6, 1, 7, '0);

        // run=0 freezes rotation while mask events still land
        repeat (3) cyc(0, 1, 4, 0, 0, '0);

        // halt everything, idle, then wake thread 5
        for (int t = 0; t < N; t++) cyc(1, 0, 0, 1, t, '0);
        repeat (3) cyc(1, 0, 0, 0, 0, '0);
        cyc(1, 1, 5, 0, 0, '0);
        repeat (9) cyc(1, 0, 0, 0, 0, '0);

        // mid-rotation reset, then first slot is tid 0
        do_reset();
        repeat (4) cyc(1, 0, 0, 0, 0, '0);

        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            stall = N'($urandom() & $urandom());
            cyc($urandom_range(0, 9) != 0,
                $urandom_range(0, 3) == 0, int'($urandom_range(0, N - 1)),
                $urandom_range(0, 3) == 0, int'($urandom_range(0, N - 1)),
                stall);
        end

        @(posedge clk);
        #2;
        mon_en = 1'b0;
        chk("queue_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
